hex_scan_ctrl: RTL and testbench

Time-multiplexed display controller that shares one hex-to-seven-segment decoder across four common-anode digits. It holds a 16-bit display value, drives the decoder's nibble input one digit at a time, and enables the matching digit for a fixed dwell. A blanking gap separates digits to prevent ghosting. New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never mixes old and new digits. Optional leading-zero blanking is supported.

---
 rtl/hex_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_hex_scan_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller sharing one external
// hex decoder; display updates are deferred to frame boundaries.
module hex_scan_ctrl #(
  parameter int unsigned DIV = 50000,
  parameter int unsigned GAP = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_val,
  input  logic [15:0] val,
  output logic        load_ready,
  input  logic        lzb_en,
  input  logic        blank_all,
  output logic [3:0]  nib,
  input  logic [6:0]  seg_in,
  output logic [6:0]  seg_n,
  output logic [3:0]  dig_n
);

  localparam int unsigned CMAX = (DIV > GAP) ? DIV : GAP;
  localparam int unsigned CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

  typedef enum logic {
    S_SHOW,
    S_GAP
  } state_t;

  state_t      state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]  idx, idx_nx;
  logic [15:0] active, active_nx;
  logic [15:0] pending, pending_nx;
  logic        pend_v, pend_v_nx;

  logic accept;
  logic boundary;
  logic blanked;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_GAP;
      cnt     <= '0;
      idx     <= 2'd3;
      active  <= '0;
      pending <= '0;
      pend_v  <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      active  <= active_nx;
      pending <= pending_nx;
      pend_v  <= pend_v_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt + CW'(1);
    idx_nx     = idx;
    active_nx  = active;
    pending_nx = pending;
    pend_v_nx  = pend_v;

    accept   = load_val && !pend_v;
    boundary = (state == S_GAP) && (cnt == GAP_LAST) && (idx == 2'd3);

    case (state)
      S_SHOW: begin
        if (cnt == DIV_LAST) begin
          state_nx = S_GAP;
          cnt_nx   = '0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nx = S_SHOW;
          cnt_nx   = '0;
          idx_nx   = idx + 2'd1;
        end
      end
      default: begin
        state_nx = S_GAP;
        cnt_nx   = '0;
      end
    endcase

    // A value accepted on the boundary cycle bypasses the pending slot so it
    // shows in the very next frame without ever dropping load_ready.
    if (boundary && pend_v) begin
      active_nx = pending;
      pend_v_nx = 1'b0;
    end else if (boundary && accept) begin
      active_nx = val;
    end else if (accept) begin
      pending_nx = val;
      pend_v_nx  = 1'b1;
    end
  end

  always_comb begin
    blanked = 1'b0;
    if (lzb_en) begin
      case (idx)
        2'd3:    blanked = (active[15:12] == 4'h0);
        2'd2:    blanked = (active[15:8] == 8'h00);
        2'd1:    blanked = (active[15:4] == 12'h000);
        default: blanked = 1'b0;
      endcase
    end
  end

  assign load_ready = !pend_v;
  assign nib        = active[{idx, 2'b00} +: 4];
  assign seg_n      = blanked ? 7'h7F : seg_in;
  assign dig_n      = (blank_all || state == S_GAP) ? 4'b1111 : ~(4'b0001 << idx);

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Randomized scoreboard bench for hex_scan_ctrl: a frame-arithmetic reference
// model queues per-cycle expectations that a negedge monitor checks.
module tb_hex_scan_ctrl;

  localparam int unsigned DIV = 4;
  localparam int unsigned GAP = 2;
  localparam int unsigned SLOT = DIV + GAP;
  localparam int unsigned FRAME = 4 * SLOT;
  localparam int unsigned NCYC = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_val;
  logic [15:0] val;
  logic        load_ready;
  logic        lzb_en;
  logic        blank_all;
  logic [3:0]  nib;
  logic [6:0]  seg_in;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;

  always #5 clk = ~clk;

  hex_scan_ctrl #(.DIV(DIV), .GAP(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_val   (load_val),
    .val        (val),
    .load_ready (load_ready),
    .lzb_en     (lzb_en),
    .blank_all  (blank_all),
    .nib        (nib),
    .seg_in     (seg_in),
    .seg_n      (seg_n),
    .dig_n      (dig_n)
  );

  // Active-low {a..g} hex decoder standing in for the shared external part.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'b0000001;  4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;  4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;  4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;  4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;  4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;  4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;  4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;  default: hex7 = 7'b0111000;
    endcase
  endfunction

  assign seg_in = hex7(nib);

  typedef struct {
    int unsigned cyc;
    logic [3:0]  dig;
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic        rdy;
  } exp_t;

  exp_t exp_q[$];
  int unsigned total = 0;
  int unsigned bad = 0;

  // Reference model state: time since reset release plus the value registers.
  bit          m_known = 1'b0;
  int unsigned m_t = 0;
  logic [15:0] m_active = '0;
  logic [15:0] m_pend = '0;
  bit          m_pv = 1'b0;

  task automatic model_step(input int unsigned cyc);
    int unsigned k, o, di;
    bit          in_gap, blk, bnd, acc;
    exp_t        e;
    if (m_known) begin
      k      = (m_t / SLOT) % 4;
      o      = m_t % SLOT;
      in_gap = (o < GAP);
      di     = in_gap ? (k + 3) % 4 : k;
      e.cyc  = cyc;
      e.nib  = 4'((m_active >> (4 * di)) & 16'hF);
      e.dig  = (blank_all || in_gap) ? 4'b1111 : ~(4'(1) << k);
      blk    = lzb_en && (di != 0) && ((m_active >> (4 * di)) == 0);
      e.seg  = blk ? 7'h7F : hex7(e.nib);
      e.rdy  = !m_pv;
      exp_q.push_back(e);
    end
    if (rst) begin
      m_known  = 1'b1;
      m_t      = 0;
      m_active = '0;
      m_pv     = 1'b0;
    end else if (m_known) begin
      acc = load_val && !m_pv;
      bnd = (m_t % FRAME) == (GAP - 1);
      if (bnd && m_pv) begin
        m_active = m_pend;
        m_pv     = 1'b0;
      end else if (bnd && acc) begin
        m_active = val;
      end else if (acc) begin
        m_pend = val;
        m_pv   = 1'b1;
      end
      m_t++;
    end
  endtask

  task automatic cmp(input string name, input int unsigned cyc,
                     input logic [15:0] got, input logic [15:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp("dig_n", e.cyc, 16'(dig_n), 16'(e.dig));
        cmp("nib", e.cyc, 16'(nib), 16'(e.nib));
        cmp("seg_n", e.cyc, 16'(seg_n), 16'(e.seg));
        cmp("load_ready", e.cyc, 16'(load_ready), 16'(e.rdy));
      end
    end
  end

  initial begin
    int unsigned phase, pct, blk_left;
    rst = 1'b1; load_val = 1'b0; val = '0; lzb_en = 1'b0; blank_all = 1'b0;
    blk_left = 0;
    for (int unsigned c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      phase = c / 400;
      rst = (c < 3) || (c >= 1700 && c < 1702) || ($urandom_range(0, 599) == 0);
      lzb_en = phase[0];
      pct = (phase % 3 == 0) ? 40 : ((phase % 3 == 1) ? 2 : 15);
      load_val = !rst && ($urandom_range(0, 99) < pct);
      case ($urandom_range(0, 4))
        0: val = 16'($urandom);
        1: val = 16'($urandom) & 16'h00FF;
        2: val = 16'($urandom) & 16'h000F;
        3: val = 16'h0050;
        default: val = 16'h0000;
      endcase
      if (blk_left == 0 && $urandom_range(0, 59) == 0)
        blk_left = $urandom_range(1, 8);
      blank_all = (blk_left != 0);
      if (blk_left != 0) blk_left--;
      model_step(c);
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
